// File: rtl/uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_frame_ctrl
//
// UART transmit frame sequencer. It sits directly downstream of a parallel-in
// serializer and runs in the TX bit-rate clock domain: one clock = one bit.
// A frame is start bit, 2**data_width data bits (LSB first, taken from the
// serializer's registered ser_data), optional parity bit, then stop bit.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> parity state, parity computation and
//                                   PAR_EN / PAR_TYP sampling are built.
//                      undefined -> no parity hardware; PAR_EN / PAR_TYP are
//                                   ignored and frames are always
//                                   2**data_width+2 cycles long.
//
// Ports:
//   CLK         in   TX bit-rate clock, rising edge
//   RST         in   synchronous active-high reset
//   P_DATA      in   parallel word, used only for parity, sampled at acceptance
//   Data_valid  in   new word available, accepted only in IDLE
//   PAR_EN      in   parity enable, sampled at acceptance
//   PAR_TYP     in   parity type (0 even, 1 odd), sampled at acceptance
//   ser_data    in   serial data bit from the serializer
//   ser_en      out  shift enable to the serializer
//   busy        out  frame in progress (blocks serializer reload)
//   TX_OUT      out  UART line, idle high
// -----------------------------------------------------------------------------
module uart_tx_frame_ctrl #(
  parameter int data_width = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [2**data_width-1:0]   P_DATA,
  input  logic                       Data_valid,
  input  logic                       PAR_EN,
  input  logic                       PAR_TYP,
  input  logic                       ser_data,
  output logic                       ser_en,
  output logic                       busy,
  output logic                       TX_OUT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [data_width-1:0]   r_bit_cnt;
  logic [data_width-1:0]   w_bit_cnt_next;
  logic                    w_accept;

  assign w_accept = (r_state == S_IDLE) && Data_valid;

`ifdef UART_TX_PARITY_EN
  logic r_par_bit;
  logic r_par_en;

  // Parity and its enable are captured once at acceptance so later input
  // changes cannot disturb the frame already on the line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else if (w_accept) begin
      r_par_bit <= (^P_DATA) ^ PAR_TYP;
      r_par_en  <= PAR_EN;
    end
  end
`else
  // Parity inputs exist on the port list for drop-in compatibility only.
  logic w_unused_par;
  assign w_unused_par = (^P_DATA) ^ PAR_EN ^ PAR_TYP;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    TX_OUT         = 1'b1;
    busy           = 1'b0;
    ser_en         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Data_valid) begin
          w_state_next   = S_START;
          w_bit_cnt_next = '0;
        end
      end

      S_START: begin
        TX_OUT       = 1'b0;
        busy         = 1'b1;
        // This shift presents data bit 0 on ser_data for the first DATA cycle.
        ser_en       = 1'b1;
        w_state_next = S_DATA;
      end

      S_DATA: begin
        TX_OUT         = ser_data;
        busy           = 1'b1;
        // The serializer is one bit ahead, so the last bit needs no shift.
        ser_en         = (r_bit_cnt != '1);
        w_bit_cnt_next = r_bit_cnt + 1'b1;
        if (r_bit_cnt == '1) begin
`ifdef UART_TX_PARITY_EN
          w_state_next = r_par_en ? S_PARITY : S_STOP;
`else
          w_state_next = S_STOP;
`endif
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        TX_OUT       = r_par_bit;
        busy         = 1'b1;
        w_state_next = S_STOP;
      end
`endif

      S_STOP: begin
        busy         = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame_ctrl
//
// Directed frames with hand-computed line patterns. The stimulus process
// pushes the expected {TX_OUT, busy, ser_en} for each future cycle into a
// queue; a monitor on the falling edge pops and compares the entry due in the
// current cycle. A small serializer model feeds ser_data.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame_ctrl;

  localparam int DW = 3;
  localparam int NB = 2**DW;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [NB-1:0] P_DATA;
  logic          Data_valid;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          ser_data;
  logic          ser_en;
  logic          busy;
  logic          TX_OUT;

  uart_tx_frame_ctrl #(.data_width(DW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_valid (Data_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT)
  );

  always #5 CLK = ~CLK;

  // Cycle index: value k at a falling edge means the state after rising edge k.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Serializer model: loads when not busy, one registered bit per ser_en.
  logic [NB-1:0] sh_reg;
  always @(posedge CLK) begin
    if (RST) begin
      sh_reg   <= '0;
      ser_data <= 1'b0;
    end else if (Data_valid && !busy) begin
      sh_reg <= P_DATA;
    end else if (ser_en) begin
      ser_data <= sh_reg[0];
      sh_reg   <= sh_reg >> 1;
    end
  end

  typedef struct {
    int         cyc;
    logic [2:0] v;      // {TX_OUT, busy, ser_en}
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic push_exp(input int c, input logic tx, input logic b,
                          input logic en, input string name);
    exp_t e;
    e.cyc  = c;
    e.v    = {tx, b, en};
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Pushes the first 'upto' cycles of a frame; a whole frame also gets the
  // idle cycle that must follow its stop bit.
  task automatic push_frame(input int c0, input logic [10:0] pat, input int len,
                            input int upto, input string name);
    for (int i = 0; i < upto; i++)
      push_exp(c0 + i, pat[i], 1'b1, (i < NB), name);
    if (upto == len)
      push_exp(c0 + len, 1'b1, 1'b0, 1'b0, {name, "_idle"});
  endtask

  // Monitor
  always @(negedge CLK) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL %s cyc=%0d: check skipped, required tx/busy/en=%b", e.name, e.cyc, e.v);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      if ({TX_OUT, busy, ser_en} !== e.v) begin
        n_miss++;
        $display("FAIL %s cyc=%0d: tx/busy/en actual=%b required=%b",
                 e.name, cyc, {TX_OUT, busy, ser_en}, e.v);
      end else begin
        $display("ok   %s cyc=%0d tx/busy/en=%b", e.name, cyc, e.v);
      end
    end
  end

  // One frame: accept on the next edge, scramble inputs after acceptance and
  // optionally pulse Data_valid mid-frame (must be ignored).
  task automatic issue(input logic [7:0] data, input logic pe, input logic pt,
                       input logic [10:0] pat_par, input logic [9:0] pat_nopar,
                       input bit pulse, input string name);
    int c0, len;
    logic [10:0] pat;
    P_DATA = data; PAR_EN = pe; PAR_TYP = pt; Data_valid = 1'b1;
    c0 = cyc + 1;
    if (PAR_BUILT && pe) begin pat = pat_par; len = 11; end
    else begin pat = {1'b0, pat_nopar}; len = 10; end
    push_frame(c0, pat, len, len, name);
    for (int i = 0; i <= len + 1; i++) begin
      @(negedge CLK);
      Data_valid = pulse && (i == 4);
      if (i == 0) begin P_DATA = ~data; PAR_EN = ~pe; PAR_TYP = ~pt; end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, len, period;
    logic [10:0] pat;

    RST = 1'b1; P_DATA = '0; Data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    for (int c = 1; c <= 3; c++) push_exp(c, 1'b1, 1'b0, 1'b0, "in_reset");
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int c = 4; c <= 23; c++) push_exp(c, 1'b1, 1'b0, 1'b0, "idle_hold");
    repeat (21) @(negedge CLK);

    issue(8'hA5, 1'b1, 1'b0, 11'b10101001010, 10'b1101001010, 1'b1, "a5_even");
    issue(8'h00, 1'b1, 1'b1, 11'b11000000000, 10'b1000000000, 1'b0, "00_odd");
    issue(8'h00, 1'b0, 1'b1, 11'b11000000000, 10'b1000000000, 1'b1, "00_nopar");

    // Back-to-back with Data_valid held: 3C then C3, one idle cycle between.
    period = PAR_BUILT ? 12 : 11;
    len    = period - 1;
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_valid = 1'b1;
    c0 = cyc + 1;
    pat = PAR_BUILT ? 11'b10001111000 : 11'b01001111000;
    push_frame(c0, pat, len, len, "b2b_3c");
    pat = PAR_BUILT ? 11'b10110000110 : 11'b01110000110;
    push_frame(c0 + period, pat, len, len, "b2b_c3");
    @(negedge CLK);
    P_DATA = 8'hC3;
    repeat (period) @(negedge CLK);
    Data_valid = 1'b0;
    repeat (len + 2) @(negedge CLK);

    // Reset during the 4th DATA cycle aborts the frame with no stop bit.
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_valid = 1'b1;
    c0 = cyc + 1;
    pat = PAR_BUILT ? 11'b10101001010 : 11'b01101001010;
    push_frame(c0, pat, PAR_BUILT ? 11 : 10, 5, "abort");
    push_exp(c0 + 5, 1'b1, 1'b0, 1'b0, "abort_rst");
    push_exp(c0 + 6, 1'b1, 1'b0, 1'b0, "abort_idle");
    @(negedge CLK);
    Data_valid = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    issue(8'h5A, 1'b1, 1'b1, 11'b11010110100, 10'b1010110100, 1'b0, "5a_odd");

    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      $display("FAIL leftover: %0d expected cycles never checked, required 0", exp_q.size());
      n_vec  += exp_q.size();
      n_miss += exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

UART transmit frame controller: accepts a byte-valid strobe, sequences start bit, 2**data_width data bits from the serializer, optional parity bit and stop bit onto the TX line, and provides the serializer's `ser_en` and `busy` controls. It sits directly downstream of the serializer in the TX clock domain and produces the final serial line output. One clock cycle equals one bit period; the clock is the TX bit-rate clock.

## Interface
- `data_width`, 3: log2 of frame data bits; frame carries 2**data_width data bits, LSB first.
- `CLK`  in  1  TX bit-rate clock; all state changes on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `P_DATA`  in  2**data_width  parallel word; used only for parity, sampled at acceptance.
- `Data_valid`  in  1  new word available; accepted only in IDLE.
- `PAR_EN`  in  1  parity enable, sampled at acceptance.
- `PAR_TYP`  in  1  parity type, 0 = even, 1 = odd, sampled at acceptance.
- `ser_data`  in  1  serial data bit from serializer, registered in serializer.
- `ser_en`  out  1  shift enable to serializer.
- `busy`  out  1  frame in progress; blocks serializer reload.
- `TX_OUT`  out  1  UART line, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. State, bit counter (data_width bits), parity-bit and parity-enable flops are registers; outputs are decoded from them.
- IDLE: `TX_OUT`=1, `busy`=0, `ser_en`=0. If `Data_valid`=1: latch `par_bit = ^P_DATA ^ PAR_TYP` and `PAR_EN`, clear bit counter, go START. The serializer loads `P_DATA` on the same edge.
- START: `TX_OUT`=0, `busy`=1, `ser_en`=1 for one cycle; go DATA.
- DATA: `TX_OUT`=`ser_data`, `busy`=1. `ser_en`=1 while bit counter < 2**data_width-1, else 0. Counter increments each DATA cycle. When counter = 2**data_width-1, go PARITY if latched parity enable=1, else STOP.
- PARITY: `TX_OUT`=latched `par_bit`, `busy`=1, `ser_en`=0; go STOP.
- STOP: `TX_OUT`=1, `busy`=1, `ser_en`=0; go IDLE unconditionally.
- The internal bit counter alone decides the end of DATA; serializer status is not consulted.
- `Data_valid` outside IDLE: ignored, not queued.
- `P_DATA`, `PAR_EN` and `PAR_TYP` changes after acceptance: no effect on current frame.
- Reset: `RST`=1 at an edge forces IDLE, clears counter and parity flops; `RST` has priority over `Data_valid`. Mid-frame reset aborts the frame: `TX_OUT`=1 from the following cycle, no stop bit emitted.

## Timing
- Reset values: `TX_OUT`=1, `busy`=0, `ser_en`=0.
- Acceptance edge E0. Cycle after E0: START (`TX_OUT`=0).
- Next 2**data_width cycles: data bit 0 through bit MSB.
- `ser_en` is high in START and in the first 2**data_width-1 DATA cycles: 2**data_width cycles total, contiguous.
- Then PARITY (1 cycle, if enabled), then STOP (1 cycle).
- Frame length: 11 cycles with parity, 10 cycles without, for the default width.
- STOP is followed by at least one IDLE cycle. With `Data_valid` held high, the minimum frame-to-frame period is 12 cycles with parity and 11 cycles without.
- `busy` rises the cycle after E0 and falls the cycle after STOP.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state, parity computation and `PAR_EN`/`PAR_TYP` sampling are built.
- `UART_TX_PARITY_EN` undefined: PARITY state and parity flops are removed. `PAR_EN` and `PAR_TYP` ports remain but are ignored. DATA always goes to STOP, and frames are always 2**data_width+2 cycles.

## Test plan
- Reset release, no `Data_valid` -> `TX_OUT`=1, `busy`=0, `ser_en`=0 held indefinitely.
- `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0 -> `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, then 1. Check `ser_en` high exactly 8 cycles and `busy` high 11 cycles.
- `P_DATA`=0x00, `PAR_EN`=1, `PAR_TYP`=1 -> parity bit 1. With `PAR_EN`=0 -> 10-cycle frame, no parity bit.
- `Data_valid` held high, `P_DATA`=0x3C then 0xC3 -> second start bit appears exactly one IDLE cycle after the first stop bit. Pulses of `Data_valid` during a frame are ignored.
- `RST` asserted in the 4th DATA cycle -> next cycle `TX_OUT`=1, `busy`=0, `ser_en`=0. A fresh 0x5A frame after reset is transmitted correctly.
- Build without `UART_TX_PARITY_EN`, `PAR_EN`=1 -> 10-cycle frame, no parity bit.
